sqrt_arbiter: RTL and testbench

- Shares one iterative integer square-root unit between two requesters.
- The unit uses odd-number subtraction: rem -= odd; odd += 2; root += 1.
- Each requester has a valid/ready request channel and a valid/ready response channel; requests are granted round-robin and processed one at a time.
- Sits between client front-ends and the square-root datapath. It also provides sequencing (load, step, test-flag, finish) that the bare datapath controller does not.

---
 rtl/sqrt_arbiter.sv | 124 ++++++++++++
 tb/tb_sqrt_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_arbiter.sv
// Two-client round-robin front end for one iterative integer square-root unit.
// Uses odd-number subtraction: each step removes the next odd number from the remainder.
module sqrt_arbiter #(
  parameter int unsigned W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [W-1:0]     req0_data,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [W/2-1:0]   rsp0_root,
  output logic [W-1:0]     rsp0_rem,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [W-1:0]     req1_data,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [W/2-1:0]   rsp1_root,
  output logic [W-1:0]     rsp1_rem,
  output logic             busy,
  output logic             grant_id
);

  localparam int unsigned RW = W / 2;
  localparam int unsigned OW = W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    rem, rem_nxt;
  logic [OW-1:0]   odd, odd_nxt;
  logic [RW-1:0]   root, root_nxt;
  logic            grant_nxt;
  logic            last, last_nxt;
  logic            sel;
  logic            any_req;

  // State and datapath registers; reset aborts any job in flight.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      rem      <= '0;
      odd      <= OW'(1);
      root     <= '0;
      grant_id <= 1'b0;
      last     <= 1'b1;
    end else begin
      state    <= state_nxt;
      rem      <= rem_nxt;
      odd      <= odd_nxt;
      root     <= root_nxt;
      grant_id <= grant_nxt;
      last     <= last_nxt;
    end
  end

  // On a tie the client that was not served last wins.
  assign any_req = req0_valid | req1_valid;
  assign sel     = (req0_valid & req1_valid) ? ~last : req1_valid;

  always_comb begin
    state_nxt  = state;
    rem_nxt    = rem;
    odd_nxt    = odd;
    root_nxt   = root;
    grant_nxt  = grant_id;
    last_nxt   = last;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    rsp0_root  = '0;
    rsp1_root  = '0;
    rsp0_rem   = '0;
    rsp1_rem   = '0;
    busy       = (state != IDLE);

    case (state)
      IDLE: begin
        if (any_req) begin
          req0_ready = ~sel;
          req1_ready = sel;
          rem_nxt    = sel ? req1_data : req0_data;
          odd_nxt    = OW'(1);
          root_nxt   = '0;
          grant_nxt  = sel;
          last_nxt   = sel;
          state_nxt  = ITER;
        end
      end
      ITER: begin
        // Remainder zero-extended so the comparison is done at odd's width.
        if ({1'b0, rem} >= odd) begin
          rem_nxt  = rem - W'(odd);
          odd_nxt  = odd + OW'(2);
          root_nxt = root + RW'(1);
        end else begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (grant_id) begin
          rsp1_valid = 1'b1;
          rsp1_root  = root;
          rsp1_rem   = rem;
          if (rsp1_ready) state_nxt = IDLE;
        end else begin
          rsp0_valid = 1'b1;
          rsp0_root  = root;
          rsp0_rem   = rem;
          if (rsp0_ready) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Directed, table-driven bench for sqrt_arbiter (W=8) with hand-written
// sequences for arbitration, response back-pressure and mid-job reset.
module tb_sqrt_arbiter;

  logic       clock;
  logic       reset;
  logic       req0_valid, req0_ready, rsp0_valid, rsp0_ready;
  logic       req1_valid, req1_ready, rsp1_valid, rsp1_ready;
  logic [7:0] req0_data, req1_data, rsp0_rem, rsp1_rem;
  logic [3:0] rsp0_root, rsp1_root;
  logic       busy, grant_id;

  int checks = 0;
  int errors = 0;

  sqrt_arbiter #(.W(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_root  (rsp0_root),
    .rsp0_rem   (rsp0_rem),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_root  (rsp1_root),
    .rsp1_rem   (rsp1_rem),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       client;
    logic [7:0] data;
    logic [3:0] root;
    logic [7:0] rem;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One complete job on an idle unit; rsp_ready of the client is held high.
  task automatic run_one(input logic c, input logic [7:0] d, input logic [3:0] er,
                         input logic [7:0] em, input string tag);
    int lat;
    if (c) begin
      req1_valid = 1'b1;
      req1_data  = d;
    end else begin
      req0_valid = 1'b1;
      req0_data  = d;
    end
    #1;
    check({tag, "_req_ready"}, 32'(c ? req1_ready : req0_ready), 32'd1);
    check({tag, "_other_ready"}, 32'(c ? req0_ready : req1_ready), 32'd0);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data  = ~d;
    req1_data  = ~d;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_grant"}, 32'(grant_id), 32'(c));
    lat = 1;
    while (!(c ? rsp1_valid : rsp0_valid) && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(er) + 32'd2);
    check({tag, "_root"}, 32'(c ? rsp1_root : rsp0_root), 32'(er));
    check({tag, "_rem"}, 32'(c ? rsp1_rem : rsp0_rem), 32'(em));
    check({tag, "_other_rsp"}, 32'(c ? rsp0_valid : rsp1_valid), 32'd0);
    tick();
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_rsp_after"}, 32'(rsp0_valid | rsp1_valid), 32'd0);
  endtask

  initial begin
    int n;
    int grants;
    int resps;
    logic expg;

    vecs[0]  = '{1'b0, 8'd16,  4'd4,  8'd0};
    vecs[1]  = '{1'b1, 8'd17,  4'd4,  8'd1};
    vecs[2]  = '{1'b1, 8'd0,   4'd0,  8'd0};
    vecs[3]  = '{1'b1, 8'd255, 4'd15, 8'd30};
    vecs[4]  = '{1'b0, 8'd9,   4'd3,  8'd0};
    vecs[5]  = '{1'b1, 8'd50,  4'd7,  8'd1};
    vecs[6]  = '{1'b0, 8'd100, 4'd10, 8'd0};
    vecs[7]  = '{1'b0, 8'd1,   4'd1,  8'd0};
    vecs[8]  = '{1'b1, 8'd2,   4'd1,  8'd1};
    vecs[9]  = '{1'b0, 8'd3,   4'd1,  8'd2};
    vecs[10] = '{1'b1, 8'd4,   4'd2,  8'd0};
    vecs[11] = '{1'b0, 8'd224, 4'd14, 8'd28};

    reset      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data  = 8'd0;
    req1_data  = 8'd0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 32'd0);
    check("rst_req_ready", 32'({req0_ready, req1_ready}), 32'd0);
    check("rst_roots", 32'({rsp0_root, rsp1_root}), 32'd0);
    check("rst_rems", 32'({rsp0_rem, rsp1_rem}), 32'd0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 12; i++)
      run_one(vecs[i].client, vecs[i].data, vecs[i].root, vecs[i].rem, $sformatf("vec%0d", i));

    // Both clients requesting continuously from a fresh reset: grants alternate from client 0.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    req0_valid = 1'b1;
    req0_data  = 8'd9;
    req1_valid = 1'b1;
    req1_data  = 8'd50;
    #1;
    grants = 0;
    resps  = 0;
    expg   = 1'b0;
    for (int cyc = 0; cyc < 300 && resps < 4; cyc++) begin
      if (grants == 4) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
      end
      check("alt_both_rsp", 32'(rsp0_valid & rsp1_valid), 32'd0);
      if (req0_ready || req1_ready) begin
        check("alt_grant", 32'(req1_ready), 32'(expg));
        check("alt_grant_excl", 32'(req0_ready & req1_ready), 32'd0);
        grants++;
        expg = ~expg;
      end
      if (rsp0_valid) begin
        check("alt_root0", 32'(rsp0_root), 32'd3);
        check("alt_rem0", 32'(rsp0_rem), 32'd0);
        resps++;
      end
      if (rsp1_valid) begin
        check("alt_root1", 32'(rsp1_root), 32'd7);
        check("alt_rem1", 32'(rsp1_rem), 32'd1);
        resps++;
      end
      tick();
    end
    check("alt_grants", 32'(grants), 32'd4);
    check("alt_resps", 32'(resps), 32'd4);
    check("alt_idle", 32'(busy), 32'd0);

    // Response back-pressure on client 0 while client 1 waits; rsp1_ready pulse is ignored.
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    req0_valid = 1'b1;
    req0_data  = 8'd100;
    #1;
    check("bp_accept", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    req1_data  = 8'd4;
    #1;
    n = 0;
    while (!rsp0_valid && n < 40) begin
      check("bp_ready_iter", 32'(req1_ready), 32'd0);
      tick();
      n++;
    end
    check("bp_reached_done", 32'(rsp0_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      rsp1_ready = (i == 2);
      #1;
      check("bp_valid", 32'(rsp0_valid), 32'd1);
      check("bp_root", 32'(rsp0_root), 32'd10);
      check("bp_rem", 32'(rsp0_rem), 32'd0);
      check("bp_req1_ready", 32'(req1_ready), 32'd0);
      check("bp_rsp1_valid", 32'(rsp1_valid), 32'd0);
      tick();
    end
    rsp1_ready = 1'b0;
    rsp0_ready = 1'b1;
    #1;
    check("bp_hs_valid", 32'(rsp0_valid), 32'd1);
    check("bp_hs_req1_ready", 32'(req1_ready), 32'd0);
    tick();
    check("bp_after_rsp0", 32'(rsp0_valid), 32'd0);
    check("bp_after_req1_ready", 32'(req1_ready), 32'd1);
    rsp1_ready = 1'b1;
    tick();
    req1_valid = 1'b0;
    n = 0;
    while (!rsp1_valid && n < 40) begin
      tick();
      n++;
    end
    check("bp_c1_root", 32'(rsp1_root), 32'd2);
    check("bp_c1_rem", 32'(rsp1_rem), 32'd0);
    tick();
    check("bp_c1_idle", 32'(busy), 32'd0);

    // Reset during ITER of client 1's 200 discards the job.
    req1_valid = 1'b1;
    req1_data  = 8'd200;
    tick();
    req1_valid = 1'b0;
    tick();
    tick();
    check("mr_busy_before", 32'(busy), 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_grant", 32'(grant_id), 32'd0);
    check("mr_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 32'd0);
    check("mr_roots", 32'({rsp0_root, rsp1_root}), 32'd0);
    check("mr_rems", 32'({rsp0_rem, rsp1_rem}), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mr_quiet_rsp", 32'({rsp0_valid, rsp1_valid}), 32'd0);
      check("mr_quiet_busy", 32'(busy), 32'd0);
    end
    run_one(1'b1, 8'd200, 4'd14, 8'd4, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
